// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams a programmed RAM address range out on valid/ready through a 2-entry buffer
module bram_stream_reader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      length,
  output logic             busy,
  output logic             done,
  output logic             ram_rd_en,
  output logic [AW-1:0]    ram_addr,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam logic [AW:0] ONE = (AW+1)'(1);
  state_t           r_state;
  logic [AW:0]      r_len, r_issued, r_sent;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_buf [2];
  logic             r_wptr, r_rptr, r_inflight, r_done;
  logic [1:0]       r_count;
  logic             w_pop, w_issue;
  logic [AW:0]      w_last_idx;
  logic [2:0]       w_pending;
  logic [AW-1:0]    w_addr_nxt;
  assign w_last_idx = r_len - ONE;
  assign w_pop      = m_valid & m_ready;
  // words already committed to the buffer after this cycle's pop; never underflows since pop needs count>0
  assign w_pending  = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue    = (r_state == READ) & (w_pending < 3'd2);
  assign w_addr_nxt = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);
  assign ram_rd_en  = w_issue;
  assign ram_addr   = r_addr;
  assign m_valid    = r_count != 2'd0;
  assign m_data     = r_buf[r_rptr];
  assign m_last     = m_valid & (r_sent == w_last_idx);
  assign busy       = r_state != IDLE;
  assign done       = r_done;
  // transfer FSM, RAM address generation and read-latency absorbing buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_issued   <= '0;
      r_sent     <= '0;
      r_addr     <= '0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      r_count    <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      if (r_inflight) begin
        r_buf[r_wptr] <= ram_rdata;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
        r_sent <= r_sent + ONE;
      end
      if (w_issue) begin
        r_addr   <= w_addr_nxt;
        r_issued <= r_issued + ONE;
      end
      case (r_state)
        IDLE: if (start) begin
          if (length == '0) r_done <= 1'b1;
          else begin
            r_state  <= READ;
            r_len    <= length;
            r_addr   <= base_addr;
            r_issued <= '0;
            r_sent   <= '0;
          end
        end
        READ:    if (w_issue && r_issued == w_last_idx) r_state <= DRAIN;
        DRAIN:   if (w_pop && m_last) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: randomized scoreboard bench for bram_stream_reader with a behavioural RAM on port B
module tb_bram_stream_reader;
  localparam int WIDTH = 16;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
  typedef struct {logic [WIDTH-1:0] d; logic l;} exp_t;
  logic clk = 0, rst_n, start, m_ready;
  logic [AW-1:0] base_addr, ram_addr;
  logic [AW:0] length;
  logic busy, done, ram_rd_en, m_valid, m_last;
  logic [WIDTH-1:0] ram_rdata, m_data;
  logic [WIDTH-1:0] mem [DEPTH];
  int checks = 0, errors = 0;
  int cyc = 0, nrd = 0, nbeat = 0, total_beats = 0, start_cyc = 0;
  int ready_mode = 0, pat_i = 0;
  bit model_busy = 0, done_q = 0, first_seen = 1, stall_prev = 0;
  logic [WIDTH-1:0] prev_data;
  logic prev_last;
  exp_t exp_q[$];
  logic [AW-1:0] addr_q[$];
  bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );
  always #5 clk = ~clk;
  // port B of the RAM: one-cycle registered read
  always @(posedge clk) if (ram_rd_en) ram_rdata <= mem[ram_addr];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // downstream ready generator
  initial begin
    m_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) m_ready = 1;
      else if (ready_mode == 1) begin
        m_ready = (pat_i == 0 || pat_i == 2 || pat_i == 5);
        pat_i = (pat_i + 1) % 6;
      end else m_ready = ($urandom_range(0, 2) != 0);
    end
  end
  // monitor and scoreboard: everything sampled mid-cycle, ahead of the edge it describes
  always @(negedge clk) begin
    bit was_busy, pop, exp_rd, next_done;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      addr_q.delete();
      model_busy = 0; done_q = 0; nrd = 0; nbeat = 0; first_seen = 1; stall_prev = 0;
    end else begin
      was_busy = model_busy;
      pop = m_valid && m_ready;
      next_done = 0;
      exp_rd = model_busy && addr_q.size() > 0 && (nrd - nbeat - int'(pop)) < 2;
      chk("rd_en", 32'(ram_rd_en), 32'(exp_rd));
      if (ram_rd_en) begin
        if (addr_q.size() == 0) chk("extra_read", 32'(1), 32'(0));
        else chk("ram_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
        nrd++;
      end
      chk("busy", 32'(busy), 32'(model_busy));
      chk("done", 32'(done), 32'(done_q));
      if (stall_prev) begin
        chk("stall_valid", 32'(m_valid), 32'(1));
        chk("stall_data", 32'(m_data), 32'(prev_data));
        chk("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && !first_seen) begin
        chk("latency", 32'(cyc - start_cyc), 32'(3));
        first_seen = 1;
      end
      if (pop) begin
        if (exp_q.size() == 0) chk("extra_beat", 32'(1), 32'(0));
        else begin
          e = exp_q.pop_front();
          chk("m_data", 32'(m_data), 32'(e.d));
          chk("m_last", 32'(m_last), 32'(e.l));
          if (e.l) begin
            model_busy = 0;
            next_done = 1;
          end
        end
        nbeat++;
        total_beats++;
      end
      stall_prev = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (start && !was_busy) begin
        if (length == 0) next_done = 1;
        else begin
          model_busy = 1;
          start_cyc = cyc;
          first_seen = 0;
          for (int i = 0; i < int'(length); i++) begin
            logic [AW-1:0] a;
            a = AW'((int'(base_addr) + i) % DEPTH);
            addr_q.push_back(a);
            exp_q.push_back('{mem[a], i == int'(length) - 1});
          end
        end
      end
      done_q = next_done;
    end
  end
  task automatic go(input int b, input int l);
    @(posedge clk);
    #1;
    start = 1;
    base_addr = AW'(b);
    length = (AW+1)'(l);
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((model_busy || done_q) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) chk("timeout", 32'(1), 32'(0));
    repeat (2) @(posedge clk);
  endtask
  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    chk(name, 32'({busy, done, ram_rd_en, m_valid, m_last, ram_addr, m_data}), 32'(0));
  endtask
  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    rst_n = 0; start = 0; base_addr = '0; length = '0;
    repeat (2) @(posedge clk);
    check_reset_outputs("reset_outputs");
    @(posedge clk);
    #1 rst_n = 1;
    mem[10] = 16'hABCD;
    go(10, 1);
    wait_idle();
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    go(0, 8);
    wait_idle();
    ready_mode = 1;
    pat_i = 0;
    go(0, 6);
    wait_idle();
    ready_mode = 0;
    mem[1022] = 16'h000A; mem[1023] = 16'h000B; mem[0] = 16'h000C; mem[1] = 16'h000D;
    go(1022, 4);
    wait_idle();
    mem[0] = 16'h1000; mem[1] = 16'h1001;
    go(0, 0);
    wait_idle();
    go(0, 8);
    repeat (3) @(posedge clk);
    #1 start = 1; base_addr = AW'(100); length = (AW+1)'(5);
    @(posedge clk);
    #1 start = 0;
    wait_idle();
    n = total_beats;
    go(0, 8);
    while (total_beats < n + 3 && cyc < 40000) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 0;
    check_reset_outputs("abort_outputs");
    @(posedge clk);
    #1 rst_n = 1;
    go(4, 2);
    wait_idle();
    ready_mode = 2;
    for (int t = 0; t < 20; t++) begin
      go($urandom_range(0, DEPTH - 1), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40));
      wait_idle();
    end
    ready_mode = 0;
    go(517, DEPTH);
    wait_idle();
    ready_mode = 2;
    go(3, DEPTH);
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #700000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
